cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares the single cacheline-wide physical memory port between the I-cache (read-only) and the D-cache (read/write) of the pipelined RV32I core.
- Sits between both cache miss-handling FSMs and pmem; fetch and memory stages stall until their cache sees a response.
- Registered FSM arbiter; one transaction in flight at a time.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 256, cacheline width in bits; offset bits OFS = $clog2(LINE_W/8).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- icache_read  in  1  I-cache line read request, held until icache_resp
- icache_address  in  ADDR_W  I-cache request address
- icache_rdata  out  LINE_W  returned line, valid with icache_resp
- icache_resp  out  1  one-cycle completion pulse
- dcache_read  in  1  D-cache line read request, held until dcache_resp
- dcache_write  in  1  D-cache line writeback request, held until dcache_resp
- dcache_address  in  ADDR_W  D-cache request address
- dcache_wdata  in  LINE_W  writeback line
- dcache_rdata  out  LINE_W  returned line, valid with dcache_resp
- dcache_resp  out  1  one-cycle completion pulse
- pmem_read  out  1  memory read strobe, held until pmem_resp
- pmem_write  out  1  memory write strobe, held until pmem_resp
- pmem_address  out  ADDR_W  line-aligned address
- pmem_wdata  out  LINE_W  write line
- pmem_rdata  in  LINE_W  read line, valid with pmem_resp
- pmem_resp  in  1  memory completion pulse

Behaviour:
- All outputs registered. Reset (async, rst_n=0): state IDLE; every output 0; rdata buffers 0; priority pointer points to D-cache.
- States: IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D, RECOVER.
- IDLE: sample requests. If D request pending (read or write) and selected by priority -> SERVE_D; else if icache_read -> SERVE_I. Grant cycle latches address (low OFS bits forced 0), wdata, direction; pmem strobe asserted the cycle after request seen (1-cycle grant latency).
- dcache_read and dcache_write both high: treat as write.
- SERVE_x: hold pmem strobe/address/wdata stable. On pmem_resp: deassert strobe, capture pmem_rdata into that requester's rdata register -> RESP_x.
- RESP_x: assert x_resp for exactly one cycle with rdata valid -> RECOVER.
- RECOVER: one idle cycle so requester can drop its request; no grant, no strobe -> IDLE. Minimum turnaround between transactions: 2 cycles after pmem_resp.
- Request dropped by cache while in SERVE_x: transaction still completes; response pulse still issued.
- pmem_resp in IDLE/RESP/RECOVER: ignored.
- rdata registers hold last value until next capture for the same requester.
- Reset mid-transaction: pmem strobe drops asynchronously, transaction abandoned, no response pulse.
- Fixed priority (macro off): D-cache wins every simultaneous request.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: 1-bit priority pointer; on simultaneous I and D requests in IDLE the pointed-to requester wins and pointer flips to the other after grant; lone requester always granted, pointer updated same way.
- Undefined: fixed D-over-I priority, no pointer register.

Decomposition:
- Shared package rv32i_types: arb_state_t enum (six states), LINE_W/OFS constants, line_t typedef (logic [LINE_W-1:0]).
- No sub-module needed; optional internal rr_pointer block only if ARB_ROUND_ROBIN_EN, kept inline.

Test Plan:
- Reset: rst_n=0 mid-SERVE_D with pmem_write=1 -> pmem_write drops immediately, all outputs 0, no dcache_resp after release.
- Lone I read: icache_read=1 addr 0x0000_0064 -> pmem_read=1, pmem_address=0x0000_0060 next cycle; pmem_resp with rdata=0xA5..A5 -> icache_resp one cycle later with icache_rdata=0xA5..A5, then 1 RECOVER cycle.
- D writeback: dcache_write=1 addr 0x8000_001F wdata=0x1234.. -> pmem_write=1, pmem_address=0x8000_0000, pmem_wdata=0x1234..; dcache_resp pulse single cycle.
- Simultaneous, fixed priority: icache_read and dcache_read both high -> D served first, I served after D's RECOVER; total I latency = D transaction + I transaction + 4 cycles overhead.
- Simultaneous, ARB_ROUND_ROBIN_EN: three back-to-back simultaneous request pairs -> grant order D, I, D.
- Spurious pmem_resp in IDLE and early request drop in SERVE_I -> no state change in IDLE; icache_resp still pulses once for dropped request.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the RV32I cache/memory arbiter: FSM states and cacheline constants.
package rv32i_types;

    localparam int LINE_W = 256;
    localparam int OFS    = $clog2(LINE_W / 8);

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [2:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RESP_I,
        RESP_D,
        RECOVER
    } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single cacheline-wide pmem port between the I-cache and D-cache, one transaction at a time.
// Optional feature: define ARB_ROUND_ROBIN_EN for alternating priority instead of fixed D-over-I.
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_address,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    import rv32i_types::*;

    localparam int OFS_BITS = $clog2(LINE_W / 8);

    arb_state_t state;
    logic       d_req;
    logic       grant_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic       ptr_d;

    always_comb begin
        d_req   = dcache_read | dcache_write;
        grant_d = d_req & (ptr_d | ~icache_read);
    end
`else
    always_comb begin
        d_req   = dcache_read | dcache_write;
        grant_d = d_req;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            icache_rdata <= '0;
            dcache_rdata <= '0;
            icache_resp  <= 1'b0;
            dcache_resp  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_d        <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // A simultaneous read+write from the D-cache is a writeback.
                    if (grant_d) begin
                        state        <= SERVE_D;
                        pmem_write   <= dcache_write;
                        pmem_read    <= ~dcache_write;
                        pmem_address <= {dcache_address[ADDR_W-1:OFS_BITS], {OFS_BITS{1'b0}}};
                        pmem_wdata   <= dcache_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                        ptr_d        <= 1'b0;
`endif
                    end else if (icache_read) begin
                        state        <= SERVE_I;
                        pmem_read    <= 1'b1;
                        pmem_write   <= 1'b0;
                        pmem_address <= {icache_address[ADDR_W-1:OFS_BITS], {OFS_BITS{1'b0}}};
                        pmem_wdata   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                        ptr_d        <= 1'b1;
`endif
                    end
                end
                SERVE_I: begin
                    if (pmem_resp) begin
                        state        <= RESP_I;
                        pmem_read    <= 1'b0;
                        pmem_write   <= 1'b0;
                        icache_rdata <= pmem_rdata;
                        icache_resp  <= 1'b1;
                    end
                end
                SERVE_D: begin
                    if (pmem_resp) begin
                        state        <= RESP_D;
                        pmem_read    <= 1'b0;
                        pmem_write   <= 1'b0;
                        dcache_rdata <= pmem_rdata;
                        dcache_resp  <= 1'b1;
                    end
                end
                RESP_I, RESP_D: begin
                    // Response pulse lasts exactly the RESP cycle; RECOVER lets the cache drop its request.
                    state        <= RECOVER;
                    icache_resp  <= 1'b0;
                    dcache_resp  <= 1'b0;
                end
                RECOVER: begin
                    state        <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    pmem_read    <= 1'b0;
                    pmem_write   <= 1'b0;
                    icache_resp  <= 1'b0;
                    dcache_resp  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter; honours ARB_ROUND_ROBIN_EN for grant-order expectations.
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         icache_read;
    logic [31:0]  icache_address;
    logic [255:0] icache_rdata;
    logic         icache_resp;
    logic         dcache_read;
    logic         dcache_write;
    logic [31:0]  dcache_address;
    logic [255:0] dcache_wdata;
    logic [255:0] dcache_rdata;
    logic         dcache_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [255:0] LINE_A5 = {32{8'hA5}};
    localparam logic [255:0] LINE_12 = {16{16'h1234}};
    localparam logic [255:0] LINE_1  = {8{32'h1111_0001}};
    localparam logic [255:0] LINE_2  = {8{32'h2222_0002}};
    localparam logic [255:0] LINE_3  = {8{32'h3333_0003}};
    localparam logic [255:0] LINE_X  = {8{32'hDEAD_BEEF}};

    cache_mem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_rdata   (dcache_rdata),
        .dcache_resp    (dcache_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a pmem strobe, answers it with data, and checks the matching response pulse.
    task automatic do_txn(input logic [255:0] data, output logic is_d);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (pmem_read || pmem_write) seen = 1'b1;
            else cyc();
        end
        check("txn_strobe_seen", {255'd0, seen}, 256'd1);
        is_d = (pmem_address == 32'h0000_4000);
        pmem_rdata = data;
        pmem_resp  = 1'b1;
        cyc();
        pmem_resp  = 1'b0;
        if (is_d) begin
            check("txn_dcache_resp", {255'd0, dcache_resp}, 256'd1);
            check("txn_dcache_rdata", dcache_rdata, data);
        end else begin
            check("txn_icache_resp", {255'd0, icache_resp}, 256'd1);
            check("txn_icache_rdata", icache_rdata, data);
        end
        cyc();
    endtask

    logic       grant_is_d [3];
    logic       exp_is_d   [3];
    logic       tmp_d;
    int         pulses;

    initial begin
        rst_n          = 1'b0;
        icache_read    = 1'b0;
        icache_address = '0;
        dcache_read    = 1'b0;
        dcache_write   = 1'b0;
        dcache_address = '0;
        dcache_wdata   = '0;
        pmem_rdata     = '0;
        pmem_resp      = 1'b0;
        #12;
        check("rst_pmem_read", {255'd0, pmem_read}, 256'd0);
        check("rst_pmem_write", {255'd0, pmem_write}, 256'd0);
        check("rst_icache_rdata", icache_rdata, 256'd0);
        check("rst_dcache_rdata", dcache_rdata, 256'd0);
        check("rst_resp", {254'd0, icache_resp, dcache_resp}, 256'd0);
        rst_n = 1'b1;
        cyc();

        // Simultaneous requests: D first, I granted after D's RECOVER.
        icache_read    = 1'b1;
        icache_address = 32'h0000_1040;
        dcache_read    = 1'b1;
        dcache_address = 32'h0000_2044;
        cyc();
        check("sim_d_strobe", {255'd0, pmem_read}, 256'd1);
        check("sim_d_addr", {224'd0, pmem_address}, {224'd0, 32'h0000_2040});
        pmem_rdata = LINE_1;
        pmem_resp  = 1'b1;
        cyc();
        pmem_resp  = 1'b0;
        check("sim_d_resp", {255'd0, dcache_resp}, 256'd1);
        check("sim_d_rdata", dcache_rdata, LINE_1);
        check("sim_i_not_yet", {255'd0, icache_resp}, 256'd0);
        dcache_read = 1'b0;
        cyc();
        check("sim_recover_no_strobe", {254'd0, pmem_read, pmem_write}, 256'd0);
        check("sim_recover_resp_low", {255'd0, dcache_resp}, 256'd0);
        cyc();
        check("sim_idle_no_strobe", {255'd0, pmem_read}, 256'd0);
        cyc();
        check("sim_i_strobe", {255'd0, pmem_read}, 256'd1);
        check("sim_i_addr", {224'd0, pmem_address}, {224'd0, 32'h0000_1040});
        pmem_rdata = LINE_2;
        pmem_resp  = 1'b1;
        cyc();
        pmem_resp  = 1'b0;
        check("sim_i_resp_latency", {255'd0, icache_resp}, 256'd1);
        check("sim_i_rdata", icache_rdata, LINE_2);
        check("sim_d_rdata_held", dcache_rdata, LINE_1);
        icache_read = 1'b0;
        cyc();
        cyc();

        // Both requests held continuously across three grants.
        icache_read    = 1'b1;
        icache_address = 32'h0000_3000;
        dcache_read    = 1'b1;
        dcache_address = 32'h0000_4000;
`ifdef ARB_ROUND_ROBIN_EN
        exp_is_d[0] = 1'b1; exp_is_d[1] = 1'b0; exp_is_d[2] = 1'b1;
`else
        exp_is_d[0] = 1'b1; exp_is_d[1] = 1'b1; exp_is_d[2] = 1'b1;
`endif
        for (int k = 0; k < 3; k++) begin
            do_txn(LINE_3 ^ 256'(k), tmp_d);
            grant_is_d[k] = tmp_d;
        end
        icache_read = 1'b0;
        dcache_read = 1'b0;
        for (int k = 0; k < 3; k++)
            check($sformatf("grant_order_%0d", k), {255'd0, grant_is_d[k]}, {255'd0, exp_is_d[k]});
        cyc();
        cyc();

        // Lone I-cache read with unaligned address.
        icache_read    = 1'b1;
        icache_address = 32'h0000_0064;
        cyc();
        check("i_strobe", {255'd0, pmem_read}, 256'd1);
        check("i_addr_aligned", {224'd0, pmem_address}, {224'd0, 32'h0000_0060});
        pmem_rdata = LINE_A5;
        pmem_resp  = 1'b1;
        cyc();
        pmem_resp  = 1'b0;
        check("i_resp", {255'd0, icache_resp}, 256'd1);
        check("i_rdata", icache_rdata, LINE_A5);
        check("i_strobe_dropped", {255'd0, pmem_read}, 256'd0);
        icache_read = 1'b0;
        cyc();
        check("i_resp_one_cycle", {255'd0, icache_resp}, 256'd0);
        cyc();

        // D-cache writeback; read+write together counts as write.
        dcache_write   = 1'b1;
        dcache_read    = 1'b1;
        dcache_address = 32'h8000_001F;
        dcache_wdata   = LINE_12;
        cyc();
        check("d_wr_strobe", {254'd0, pmem_write, pmem_read}, 256'd2);
        check("d_wr_addr", {224'd0, pmem_address}, {224'd0, 32'h8000_0000});
        check("d_wr_wdata", pmem_wdata, LINE_12);
        dcache_wdata = '0;
        cyc();
        check("d_wr_wdata_stable", pmem_wdata, LINE_12);
        pmem_rdata = LINE_2;
        pmem_resp  = 1'b1;
        cyc();
        pmem_resp  = 1'b0;
        check("d_wr_resp", {255'd0, dcache_resp}, 256'd1);
        check("d_wr_strobe_dropped", {255'd0, pmem_write}, 256'd0);
        dcache_write = 1'b0;
        dcache_read  = 1'b0;
        cyc();
        check("d_wr_resp_one_cycle", {255'd0, dcache_resp}, 256'd0);
        cyc();

        // Spurious pmem_resp while idle is ignored.
        pmem_rdata = LINE_X;
        pmem_resp  = 1'b1;
        cyc();
        pmem_resp  = 1'b0;
        cyc();
        check("spur_no_strobe", {254'd0, pmem_read, pmem_write}, 256'd0);
        check("spur_no_resp", {254'd0, icache_resp, dcache_resp}, 256'd0);
        check("spur_rdata_held", icache_rdata, LINE_A5);

        // I request dropped during SERVE_I still completes with one pulse.
        icache_read    = 1'b1;
        icache_address = 32'h0000_0ABC;
        cyc();
        icache_read = 1'b0;
        cyc();
        cyc();
        check("drop_strobe_held", {255'd0, pmem_read}, 256'd1);
        check("drop_addr_held", {224'd0, pmem_address}, {224'd0, 32'h0000_0AA0});
        pmem_rdata = LINE_3;
        pmem_resp  = 1'b1;
        cyc();
        pmem_resp  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (icache_resp) pulses++;
            if (i == 0) check("drop_rdata", icache_rdata, LINE_3);
            cyc();
        end
        check("drop_pulse_count", 256'(pulses), 256'd1);

        // Asynchronous reset in the middle of a D writeback.
        dcache_write   = 1'b1;
        dcache_address = 32'h8000_0040;
        dcache_wdata   = LINE_12;
        cyc();
        check("rmid_strobe_before", {255'd0, pmem_write}, 256'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rmid_strobe_async", {255'd0, pmem_write}, 256'd0);
        check("rmid_addr", {224'd0, pmem_address}, 256'd0);
        check("rmid_wdata", pmem_wdata, 256'd0);
        check("rmid_rdata", {icache_rdata ^ dcache_rdata}, 256'd0);
        dcache_write = 1'b0;
        cyc();
        pmem_resp = 1'b1;
        cyc();
        pmem_resp = 1'b0;
        rst_n     = 1'b1;
        pulses    = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (dcache_resp || pmem_write || pmem_read) pulses++;
        end
        check("rmid_no_resp_after", 256'(pulses), 256'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
